// File: rtl/ones_count_if.sv
// Bus between a ones-counter source and the frame accumulator.
//   start, clear, in_valid, y1, y0 : source -> accumulator controls and sample
//   busy, done, sum, overflow      : accumulator -> source status and result
interface ones_count_if #(
    parameter int unsigned SUM_W = 5
);
    logic             start;
    logic             clear;
    logic             in_valid;
    logic             y1;
    logic             y0;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] sum;
    logic             overflow;

    // Source side: drives the sample and controls, observes the result.
    modport master (
        output start, clear, in_valid, y1, y0,
        input  busy, done, sum, overflow
    );

    // Accumulator side.
    modport slave (
        input  start, clear, in_valid, y1, y0,
        output busy, done, sum, overflow
    );
endinterface

// File: rtl/ones_count_accumulator.sv
// Sums FRAME_LEN accepted 2-bit ones-count samples into a saturating total,
// then reports it with a one-cycle done pulse and a sticky overflow flag.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   acc_if : ones_count_if.slave (start/clear/in_valid/y1/y0 in;
//            busy/done/sum/overflow out, all registered)
module ones_count_accumulator #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned SUM_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    ones_count_if.slave        acc_if
);
    localparam int unsigned ACC_W = SUM_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SUM_W-1:0] SUM_MAX  = {SUM_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SUM_W-1:0] sum_q,   sum_d;
    logic             ovf_q,   ovf_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [ACC_W-1:0] add_c;

    // One extra bit catches the carry out; a single 0..3 add can never wrap twice.
    assign add_c = {1'b0, sum_q} + ACC_W'({acc_if.y1, acc_if.y0});

    // Next-state and result update; clear overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (acc_if.start) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACCUM: begin
                if (acc_if.in_valid) begin
                    if (add_c[SUM_W]) begin
                        sum_d = SUM_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        sum_d = add_c[SUM_W-1:0];
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (acc_if.clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
        end

        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d == S_ACCUM);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign acc_if.busy     = busy_q;
    assign acc_if.done     = done_q;
    assign acc_if.sum      = sum_q;
    assign acc_if.overflow = ovf_q;
endmodule

// File: tb/tb_ones_count_accumulator.sv
// Directed, table-driven bench for ones_count_accumulator.
// dut_a: default SUM_W=5; dut_b: SUM_W=4 to reach saturation. Both share stimulus.
module tb_ones_count_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [1:0] y = 2'b00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ones_count_if #(.SUM_W(5)) bus_a ();
    ones_count_if #(.SUM_W(4)) bus_b ();

    assign bus_a.start    = start;
    assign bus_a.clear    = clear;
    assign bus_a.in_valid = in_valid;
    assign bus_a.y1       = y[1];
    assign bus_a.y0       = y[0];
    assign bus_b.start    = start;
    assign bus_b.clear    = clear;
    assign bus_b.in_valid = in_valid;
    assign bus_b.y1       = y[1];
    assign bus_b.y0       = y[0];

    ones_count_accumulator #(.FRAME_LEN(8), .CNT_W(3), .SUM_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .acc_if(bus_a)
    );
    ones_count_accumulator #(.FRAME_LEN(8), .CNT_W(3), .SUM_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .acc_if(bus_b)
    );

    typedef struct {
        logic       s;
        logic       c;
        logic       v;
        logic [1:0] y;
        logic       eb;
        logic       ed;
        logic [4:0] es;
        logic       eo;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add_row(input logic s, input logic c, input logic v, input logic [1:0] yy,
                           input logic eb, input logic ed, input logic [4:0] es, input logic eo);
        vec_t r;
        r.s = s; r.c = c; r.v = v; r.y = yy;
        r.eb = eb; r.ed = ed; r.es = es; r.eo = eo;
        vq.push_back(r);
    endtask

    task automatic drive(input logic s, input logic c, input logic v, input logic [1:0] yy);
        start = s; clear = c; in_valid = v; y = yy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        logic [1:0] gappy [8];
        gappy[0] = 2'b01; gappy[1] = 2'b10; gappy[2] = 2'b00; gappy[3] = 2'b11;
        gappy[4] = 2'b01; gappy[5] = 2'b01; gappy[6] = 2'b10; gappy[7] = 2'b11;

        // Full frame of 3s back to back: 24, one-cycle done.
        add_row(1, 0, 0, 2'b00, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add_row(0, 0, 1, 2'b11, (k < 8), (k == 8), 5'(3 * k), 0);
        add_row(0, 0, 0, 2'b00, 0, 0, 24, 0);
        add_row(0, 0, 0, 2'b00, 0, 0, 24, 0);

        // Gappy frame; invalid cycles carry 11 which must be ignored. 1+2+0+3+1+1+2+3 = 13.
        add_row(1, 0, 0, 2'b00, 1, 0, 0, 0);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc += int'(gappy[k]);
            add_row(0, 0, 1, gappy[k], (k < 7), (k == 7), 5'(acc), 0);
            if (k < 7) add_row(0, 0, 0, 2'b11, 1, 0, 5'(acc), 0);
        end
        // in_valid in IDLE does not touch the held result.
        add_row(0, 0, 1, 2'b11, 0, 0, 13, 0);
        add_row(0, 0, 1, 2'b11, 0, 0, 13, 0);

        // start during ACCUM (sample 3) and during DONE is ignored. 1+2+3+5*1 = 11.
        add_row(1, 0, 0, 2'b00, 1, 0, 0, 0);
        add_row(0, 0, 1, 2'b01, 1, 0, 1, 0);
        add_row(0, 0, 1, 2'b10, 1, 0, 3, 0);
        add_row(1, 0, 1, 2'b11, 1, 0, 6, 0);
        for (int k = 1; k <= 5; k++)
            add_row(0, 0, 1, 2'b01, (k < 5), (k == 5), 5'(6 + k), 0);
        add_row(1, 0, 0, 2'b00, 0, 0, 11, 0);
        add_row(0, 0, 0, 2'b00, 0, 0, 11, 0);

        // clear at sample 5 aborts and zeroes.
        add_row(1, 0, 0, 2'b00, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            add_row(0, 0, 1, 2'b10, 1, 0, 5'(2 * k), 0);
        add_row(0, 1, 1, 2'b10, 0, 0, 0, 0);
        add_row(0, 0, 1, 2'b10, 0, 0, 0, 0);
        // clear beats start in IDLE.
        add_row(1, 1, 0, 2'b00, 0, 0, 0, 0);
        add_row(0, 0, 0, 2'b00, 0, 0, 0, 0);
        // clear on the last valid sample: no done pulse.
        add_row(1, 0, 0, 2'b00, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++)
            add_row(0, 0, 1, 2'b01, 1, 0, 5'(k), 0);
        add_row(0, 1, 1, 2'b01, 0, 0, 0, 0);
        add_row(0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 0, 32'(bus_a.busy), 0);
        check("rst_done", 0, 32'(bus_a.done), 0);
        check("rst_sum", 0, 32'(bus_a.sum), 0);
        check("rst_ovf", 0, 32'(bus_a.overflow), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 2'b00);

        foreach (vq[i]) begin
            drive(vq[i].s, vq[i].c, vq[i].v, vq[i].y);
            check("busy", i, 32'(bus_a.busy), 32'(vq[i].eb));
            check("done", i, 32'(bus_a.done), 32'(vq[i].ed));
            check("sum", i, 32'(bus_a.sum), 32'(vq[i].es));
            check("ovf", i, 32'(bus_a.overflow), 32'(vq[i].eo));
        end

        // Asynchronous reset mid-frame, between clock edges.
        drive(1, 0, 0, 2'b00);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 2'b11);
        check("pre_rst_sum", 0, 32'(bus_a.sum), 9);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_busy", 0, 32'(bus_a.busy), 0);
        check("async_sum", 0, 32'(bus_a.sum), 0);
        check("async_ovf", 0, 32'(bus_a.overflow), 0);
        check("async_busy_b", 0, 32'(bus_b.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 2'b11);
            check("post_rst_busy", k, 32'(bus_a.busy), 0);
            check("post_rst_sum", k, 32'(bus_a.sum), 0);
        end

        // Saturation on the 4-bit accumulator.
        drive(1, 0, 0, 2'b00);
        check("sat_start_busy", 0, 32'(bus_b.busy), 1);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 1, 2'b11);
            check("sat_sum", k, 32'(bus_b.sum), (3 * k > 15) ? 15 : 3 * k);
            check("sat_ovf", k, 32'(bus_b.overflow), (3 * k > 15) ? 1 : 0);
            check("sat_done", k, 32'(bus_b.done), (k == 8) ? 1 : 0);
        end
        check("wide_sum", 0, 32'(bus_a.sum), 24);
        check("wide_ovf", 0, 32'(bus_a.overflow), 0);
        drive(0, 0, 0, 2'b00);
        check("sat_hold_sum", 0, 32'(bus_b.sum), 15);
        check("sat_hold_ovf", 0, 32'(bus_b.overflow), 1);
        check("sat_hold_done", 0, 32'(bus_b.done), 0);
        drive(1, 0, 0, 2'b00);
        check("sat_restart_sum", 0, 32'(bus_b.sum), 0);
        check("sat_restart_ovf", 0, 32'(bus_b.overflow), 0);
        check("sat_restart_busy", 0, 32'(bus_b.busy), 1);
        drive(0, 1, 0, 2'b00);
        check("final_busy", 0, 32'(bus_b.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
